// File: rtl/sop_cover_eval_if.sv
// Request, result and configuration signals of the sum-of-products cover evaluator.
// The master drives requests and configuration; the slave is the evaluator.
interface sop_cover_eval_if #(
  parameter int unsigned N_IN  = 11,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
);
  logic            cfg_we;
  logic [AW-1:0]   cfg_addr;
  logic [N_IN-1:0] cfg_care;
  logic [N_IN-1:0] cfg_val;
  logic            cfg_len_we;
  logic [AW:0]     cfg_len;
  logic            busy;
  logic            in_valid;
  logic            in_ready;
  logic [N_IN-1:0] in_vec;
  logic            in_mode;
  logic            out_valid;
  logic            out_ready;
  logic            out_f;
  logic [AW-1:0]   out_first;
  logic [AW:0]     out_hits;

  modport master (
    output cfg_we, cfg_addr, cfg_care, cfg_val, cfg_len_we, cfg_len,
    output in_valid, in_vec, in_mode, out_ready,
    input  busy, in_ready, out_valid, out_f, out_first, out_hits
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_care, cfg_val, cfg_len_we, cfg_len,
    input  in_valid, in_vec, in_mode, out_ready,
    output busy, in_ready, out_valid, out_f, out_first, out_hits
  );
endinterface

// File: rtl/sop_cover_eval.sv
// Run-time programmable sum-of-products evaluator: scans one cube per cycle and
// reports function value, first matching cube and number of matching cubes.
module sop_cover_eval #(
  parameter int unsigned N_IN  = 11,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input logic             clk,
  input logic             reset,
  sop_cover_eval_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   first_q, first_d;
  logic [AW:0]     hits_q, hits_d;
  logic [AW:0]     n_cubes_q, n_cubes_d;
  logic            found_q, found_d;
  logic            mode_q, mode_d;
  logic [N_IN-1:0] vec_q, vec_d;

  logic [N_IN-1:0] care_q [DEPTH];
  logic [N_IN-1:0] care_d [DEPTH];
  logic [N_IN-1:0] val_q  [DEPTH];
  logic [N_IN-1:0] val_d  [DEPTH];

  logic cfg_en;
  logic cube_hit;
  logic last_cube;
  logic scan_exit;

  always_comb begin
    cfg_en    = (state_q == StIdle);
    cube_hit  = ((vec_q ^ val_q[idx_q]) & care_q[idx_q]) == '0;
    last_cube = ({1'b0, idx_q} == (n_cubes_q - (AW+1)'(1)));
    // First-hit mode stops on the first match; count-all runs to the last cube.
    scan_exit = (cube_hit && !mode_q) || last_cube;
  end

  // Cube storage: plain register array, not reset, written only while idle.
  always_comb begin
    care_d = care_q;
    val_d  = val_q;
    if (cfg_en && bus.cfg_we && ({1'b0, bus.cfg_addr} < (AW+1)'(DEPTH))) begin
      care_d[bus.cfg_addr] = bus.cfg_care;
      val_d[bus.cfg_addr]  = bus.cfg_val;
    end
  end

  always_ff @(posedge clk) begin
    care_q <= care_d;
    val_q  <= val_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      first_q   <= '0;
      hits_q    <= '0;
      n_cubes_q <= '0;
      found_q   <= 1'b0;
      mode_q    <= 1'b0;
      vec_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      first_q   <= first_d;
      hits_q    <= hits_d;
      n_cubes_q <= n_cubes_d;
      found_q   <= found_d;
      mode_q    <= mode_d;
      vec_q     <= vec_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    first_d   = first_q;
    hits_d    = hits_q;
    n_cubes_d = n_cubes_q;
    found_d   = found_q;
    mode_d    = mode_q;
    vec_d     = vec_q;

    if (cfg_en && bus.cfg_len_we) begin
      n_cubes_d = (bus.cfg_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.cfg_len;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          vec_d   = bus.in_vec;
          mode_d  = bus.in_mode;
          idx_d   = '0;
          hits_d  = '0;
          first_d = '0;
          found_d = 1'b0;
          state_d = (n_cubes_q == '0) ? StDone : StScan;
        end
      end
      StScan: begin
        if (cube_hit) begin
          hits_d = hits_q + (AW+1)'(1);
          if (!found_q) begin
            first_d = idx_q;
            found_d = 1'b1;
          end
        end
        if (scan_exit) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != StIdle);
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.out_f     = 1'b0;
    bus.out_first = '0;
    bus.out_hits  = '0;
    if (state_q == StDone) begin
      bus.out_f     = found_q;
      bus.out_first = first_q;
      bus.out_hits  = hits_q;
    end
  end

endmodule

// File: tb/tb_sop_cover_eval.sv
// Scoreboard bench for sop_cover_eval: expectations are queued when a request is
// driven and compared (value and latency) when out_valid appears.
module tb_sop_cover_eval;
  localparam int unsigned N_IN  = 11;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef struct {
    logic          f;
    logic [AW-1:0] first;
    logic [AW:0]   hits;
    int            lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sop_cover_eval_if #(.N_IN(N_IN), .DEPTH(DEPTH)) bus ();

  sop_cover_eval #(.N_IN(N_IN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  exp_t sb[$];

  logic [N_IN-1:0] m_care [DEPTH];
  logic [N_IN-1:0] m_val  [DEPTH];
  int              m_len;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic golden(input logic [N_IN-1:0] v);
    return (v[0] & ~v[1] & v[2]) | (v[3] & v[4]) | (~v[5] & v[6] & ~v[7] & v[10]) |
           (v[8] & ~v[9]) | (v[0] & v[2] & ~v[3]);
  endfunction

  // Inputs change #1 after a rising edge; tasks always return at that phase.
  task automatic cfg_write(input int addr, input logic [N_IN-1:0] care, input logic [N_IN-1:0] val,
                           input logic we, input int len, input logic len_we);
    bus.cfg_we     = we;
    bus.cfg_addr   = AW'(addr);
    bus.cfg_care   = care;
    bus.cfg_val    = val;
    bus.cfg_len_we = len_we;
    bus.cfg_len    = (AW+1)'(len);
    @(posedge clk); #1;
    bus.cfg_we     = 1'b0;
    bus.cfg_len_we = 1'b0;
    if (we) begin
      m_care[addr] = care;
      m_val[addr]  = val;
    end
    if (len_we) m_len = (len > int'(DEPTH)) ? int'(DEPTH) : len;
  endtask

  task automatic model(input logic [N_IN-1:0] vec, input logic mode, output exp_t e);
    e.f     = 1'b0;
    e.first = '0;
    e.hits  = '0;
    e.lat   = m_len + 1;
    for (int i = 0; i < m_len; i++) begin
      if (((vec ^ m_val[i]) & m_care[i]) == '0) begin
        if (!e.f) begin
          e.f     = 1'b1;
          e.first = AW'(i);
        end
        e.hits = e.hits + (AW+1)'(1);
        if (!mode) begin
          e.lat = i + 2;
          break;
        end
      end
    end
  endtask

  task automatic push_exp(input logic f, input int first, input int hits, input int lat);
    exp_t e;
    e.f     = f;
    e.first = AW'(first);
    e.hits  = (AW+1)'(hits);
    e.lat   = lat;
    sb.push_back(e);
  endtask

  // hold: cycles to keep out_ready low after DONE; hold_wr: try a cube write mid-hold.
  task automatic run_req(input logic [N_IN-1:0] vec, input logic mode, input int hold,
                         input logic hold_wr);
    exp_t e;
    int   cyc;
    bus.in_vec   = vec;
    bus.in_mode  = mode;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 1;
    while (!bus.out_valid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check_eq("out_valid", 32'(bus.out_valid), 32'd1);
      check_eq("latency", 32'(cyc), 32'(e.lat));
      check_eq("out_f", 32'(bus.out_f), 32'(e.f));
      check_eq("out_first", 32'(bus.out_first), 32'(e.first));
      check_eq("out_hits", 32'(bus.out_hits), 32'(e.hits));
      check_eq("hits_vs_f", 32'(bus.out_hits != '0), 32'(e.f));
      check_eq("in_ready_done", 32'(bus.in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
        if (hold_wr && i == 3) begin
          bus.cfg_we   = 1'b1;
          bus.cfg_addr = AW'(1);
          bus.cfg_care = 11'h7FF;
          bus.cfg_val  = 11'h000;
        end
        @(posedge clk); #1;
        bus.cfg_we = 1'b0;
        check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
        check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
        check_eq("hold_f", 32'(bus.out_f), 32'(e.f));
        check_eq("hold_first", 32'(bus.out_first), 32'(e.first));
        check_eq("hold_hits", 32'(bus.out_hits), 32'(e.hits));
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check_eq("valid_cleared", 32'(bus.out_valid), 32'd0);
    check_eq("ready_again", 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    exp_t e;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_care   = '0;
    bus.cfg_val    = '0;
    bus.cfg_len_we = 1'b0;
    bus.cfg_len    = '0;
    bus.in_valid   = 1'b0;
    bus.in_vec     = '0;
    bus.in_mode    = 1'b0;
    bus.out_ready  = 1'b0;
    m_len          = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      m_care[i] = '0;
      m_val[i]  = '0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_f", 32'(bus.out_f), 32'd0);
    check_eq("rst_out_first", 32'(bus.out_first), 32'd0);
    check_eq("rst_out_hits", 32'(bus.out_hits), 32'd0);

    // Three-cube cover; last cube and length written in the same cycle.
    cfg_write(0, 11'h7FF, 11'h000, 1'b1, 0, 1'b0);
    cfg_write(1, 11'h003, 11'h003, 1'b1, 0, 1'b0);
    cfg_write(2, 11'h400, 11'h400, 1'b1, 3, 1'b1);
    push_exp(1'b1, 1, 2, 4); run_req(11'h403, 1'b1, 0, 1'b0);
    push_exp(1'b1, 1, 1, 3); run_req(11'h403, 1'b0, 0, 1'b0);
    push_exp(1'b0, 0, 0, 4); run_req(11'h004, 1'b0, 0, 1'b0);

    // Empty cover, then saturated length over 64 all-don't-care cubes.
    cfg_write(0, '0, '0, 1'b0, 0, 1'b1);
    push_exp(1'b0, 0, 0, 1); run_req(11'h123, 1'b1, 0, 1'b0);
    for (int i = 0; i < int'(DEPTH); i++) cfg_write(i, '0, '0, 1'b1, 0, 1'b0);
    cfg_write(0, '0, '0, 1'b0, 80, 1'b1);
    push_exp(1'b1, 0, 64, 65); run_req(11'h555, 1'b1, 0, 1'b0);
    push_exp(1'b1, 0, 1, 2);   run_req(11'h2AA, 1'b0, 0, 1'b0);

    // Stall in DONE with a dropped cube write, then repeat the same request.
    cfg_write(0, 11'h7FF, 11'h000, 1'b1, 0, 1'b0);
    cfg_write(1, 11'h003, 11'h003, 1'b1, 0, 1'b0);
    cfg_write(2, 11'h400, 11'h400, 1'b1, 3, 1'b1);
    push_exp(1'b1, 1, 2, 4); run_req(11'h403, 1'b1, 10, 1'b1);
    push_exp(1'b1, 1, 2, 4); run_req(11'h403, 1'b1, 0, 1'b0);

    // Reset during the second SCAN cycle of a five-cube count-all request.
    for (int i = 0; i < 5; i++) cfg_write(i, '0, '0, 1'b1, 5, (i == 4));
    bus.in_vec   = 11'h0F0;
    bus.in_mode  = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check_eq("scan_busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_len = 0;
    check_eq("midrst_busy", 32'(bus.busy), 32'd0);
    check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    push_exp(1'b0, 0, 0, 1); run_req(11'h403, 1'b1, 0, 1'b0);

    // Exhaustive sweep of a five-cube cover with overlapping implicants.
    cfg_write(0, 11'h007, 11'h005, 1'b1, 0, 1'b0);
    cfg_write(1, 11'h018, 11'h018, 1'b1, 0, 1'b0);
    cfg_write(2, 11'h4E0, 11'h440, 1'b1, 0, 1'b0);
    cfg_write(3, 11'h300, 11'h100, 1'b1, 0, 1'b0);
    cfg_write(4, 11'h00D, 11'h005, 1'b1, 5, 1'b1);
    for (int v = 0; v < 2048; v++) begin
      for (int m = 0; m < 2; m++) begin
        model(11'(v), m[0], e);
        e.f = golden(11'(v));
        sb.push_back(e);
        run_req(11'(v), m[0], 0, 1'b0);
      end
    end

    check_eq("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sop_cover_eval.md
# sop_cover_eval

Programmable sum-of-products evaluator for minimized covers. It holds up to DEPTH implicant cubes over N_IN variables and evaluates a cover against one input vector per transaction, scanning one cube per cycle. It returns the function value, the index of the first matching cube, and optionally the total number of covering cubes. It replaces hard-wired minimized-expression modules: a cover produced by the minimizer is loaded at run time instead of being re-synthesised. It is also used to check minimizer output for redundant implicants (multi-hit minterms).

## Interface
Parameters:
- N_IN, 11, number of input variables; in_vec[0] is the first variable (a), in_vec[1] is b, and so on.
- DEPTH, 64, maximum number of cubes; must be at least 2.
- AW, $clog2(DEPTH), cube address width (derived).

Ports:
- clk  in  1  single clock; everything is updated on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cfg_we  in  1  cube write strobe.
- cfg_addr  in  AW  cube index to write.
- cfg_care  in  N_IN  literal-present mask; bit=0 means don't-care.
- cfg_val  in  N_IN  literal polarity; 1 means true, 0 means complemented. Meaningful only where care=1.
- cfg_len_we  in  1  cover length write strobe.
- cfg_len  in  AW+1  number of active cubes; values above DEPTH saturate to DEPTH.
- busy  out  1  high while state is not IDLE.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- in_vec  in  N_IN  input assignment.
- in_mode  in  1  0 = first-hit (early exit), 1 = count-all.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed.
- out_f  out  1  function value.
- out_first  out  AW  index of the lowest matching cube; 0 if none matches.
- out_hits  out  AW+1  number of matching cubes. In first-hit mode this is 0 or 1.

## Operation
- Cube i matches when ((in_vec ^ val[i]) & care[i]) == 0. A cube with care=0 matches every input.
- Cube storage is a register array with combinational read. It is not reset. n_cubes resets to 0.
- Configuration writes are applied only when busy=0. cfg_we or cfg_len_we asserted while busy=1 is dropped silently. If both strobes fire in the same cycle, both writes take effect.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - On in_valid&in_ready, latch in_vec and in_mode, and clear idx, hits, first and found.
  - Go to SCAN. If n_cubes==0, go directly to DONE with out_f=0.
- SCAN evaluates cube[idx] every cycle. On a match:
  - hits increments.
  - If found==0: first←idx, found←1.
- SCAN exits to DONE when either of these holds:
  - in_mode==0 and the cube matched.
  - idx==n_cubes-1.
  - Otherwise idx increments. idx never wraps past n_cubes-1.
- DONE:
  - out_valid=1; out_f=found, plus out_first and out_hits, all held stable.
  - On out_ready, go to IDLE and clear out_valid.
  - The next request cannot be accepted in the same cycle as the out_ready handshake (in_ready=0 in DONE).
- Arithmetic: hits is AW+1 bits wide and cannot overflow, since it is at most DEPTH.

## Timing
- Reset values: state=IDLE, busy=0, in_ready=1, out_valid=0, out_f=0, out_first=0, out_hits=0, n_cubes=0.
- Reset asserted mid-SCAN or mid-DONE: the next cycle is IDLE and any pending result is discarded. The cover length is lost and must be rewritten.
- Latency, counting the acceptance cycle as cycle 0:
  - Count-all with n cubes: out_valid is first high in cycle n+1.
  - First-hit at index k: out_valid is first high in cycle k+2.
  - First-hit with no match: out_valid is first high in cycle n+1.
  - n_cubes==0: out_valid is high in cycle 1.
- Throughput: one transaction per (latency + 1) cycles at best, because of the DONE→IDLE turnaround.
- A config write to a cube in cycle c is visible to a request accepted in cycle c+1 or later.
- out_valid stays high with stable outputs for any number of cycles while out_ready=0.

## Test plan
- Load 3 cubes: cube0 care=0x7FF val=0x000; cube1 care=0x003 val=0x003; cube2 care=0x400 val=0x400. Set cfg_len=3.
  - Count-all, in_vec=0x403 → out_f=1, out_first=1, out_hits=2; out_valid in cycle 4.
- Same cover, first-hit mode:
  - in_vec=0x403 → out_f=1, out_first=1, out_hits=1; out_valid in cycle 3.
  - in_vec=0x004 → out_f=0, out_hits=0, out_first=0; out_valid in cycle 4.
- Empty cover (cfg_len=0), any vector → out_f=0 in cycle 1. Then cfg_len=80 with DEPTH=64 → length saturates to 64; a count-all request over 64 care=0 cubes gives out_hits=64.
- Hold out_ready=0 for 10 cycles after DONE → outputs stable and in_ready=0 throughout. A cfg_we issued during that hold is dropped: re-evaluating the same vector gives an identical result.
- Assert reset in SCAN cycle 2 of a 5-cube count-all request → busy=0, out_valid=0 and n_cubes=0 the next cycle. A subsequent request returns out_f=0 in cycle 1.
- Exhaustive check: load a minimized cover of an 11-input function and sweep all 2048 vectors in both modes → out_f matches the golden SOP in both modes, and out_hits ≥ 1 exactly where the function is 1.
